ddr_write_back: RTL and testbench
=================================

DDR_WRITE_BACK -- requirements
Module: ddr_write_back

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of 128-bit entries in the packed-word FIFO (power of two, >=2).
REQ-002 SHALL have port iCLK  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a write-back job; sampled only while done=1.
REQ-005 SHALL have port start_address  input  26  first DDR3 word address; latched on accepted start.
REQ-006 SHALL have port stride  input  10  128-bit words per image row; latched on accepted start.
REQ-007 SHALL have port rows  input  10  number of rows; latched on accepted start.
REQ-008 SHALL have port done  output  1  high when idle or job complete.
REQ-009 SHALL have port pix_valid  input  1  upstream result pixel valid.
REQ-010 SHALL have port pix_data  input  32  result pixel.
REQ-011 SHALL have port pix_ready  output  1  block accepts pixel this cycle.
REQ-012 SHALL have ports avl_address output 26, avl_writedata output 128, avl_write output 1, avl_read output 1, avl_burstbegin output 1, avl_wait_request_n input 1 (high = controller accepts command).

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start while done=1; RUN->DONE when words_written = stride*rows; DONE->RUN on start.
REQ-014 SHALL compute total = stride*rows as 20-bit unsigned product at start; total=0 -> stay/return to DONE next cycle, no pixels accepted, no writes.
REQ-015 SHALL drive done=0 from the cycle after an accepted start until the cycle after the last write is accepted, then done=1.
REQ-016 SHALL transfer a pixel only on a cycle where pix_valid=1 and pix_ready=1.
REQ-017 SHALL drive pix_ready=1 only in RUN, with FIFO not full after any same-cycle pop considered, and pixels_accepted < 4*total.
REQ-018 SHALL pack pixels 4 per word: k-th pixel of a group (k=0..3) into avl_writedata bits [32k+31:32k], lane 0 first-arriving.
REQ-019 SHALL push the packed word into the FIFO on the cycle its 4th pixel is accepted; pixel acceptance continues uninterrupted.
REQ-020 SHALL assert avl_write whenever FIFO is non-empty in RUN, presenting FIFO head on avl_writedata.
REQ-021 SHALL hold avl_address, avl_writedata, avl_write stable while avl_write=1 and avl_wait_request_n=0.
REQ-022 SHALL, on an edge with avl_write=1 and avl_wait_request_n=1, pop the FIFO, increment avl_address by 1 and words_written by 1.
REQ-023 SHALL drive avl_read=0 always and avl_burstbegin = avl_write (single-word bursts).
REQ-024 SHALL wrap avl_address modulo 2^26 without error.
REQ-025 SHALL support simultaneous push and pop in one cycle with count unchanged, including when FIFO is full.
REQ-026 SHALL ignore start while done=0; pix_valid outside RUN has no effect.
REQ-027 SHALL sustain one pixel per cycle and one write per cycle when avl_wait_request_n stays high.

Reset
REQ-028 SHALL, when reset=0 at a rising edge: state=IDLE, done=1, avl_write=0, avl_read=0, avl_burstbegin=0, avl_address=0, avl_writedata=0, pix_ready=0, FIFO empty, lane and all counters 0.
REQ-029 SHALL abort a job on mid-operation reset: pending and partial words discarded, avl_write low at the first output after the reset edge.

Verification
REQ-030 Basic: start_address=0x100, stride=2, rows=1, pixels 1..8 back-to-back, wait_request_n=1 -> writes at 0x100 data {4,3,2,1} and 0x101 data {8,7,6,5} (lane3..lane0), done=1 after.
REQ-031 Stall: stride=4, rows=2, wait_request_n=0 for 10 cycles mid-job -> address/data held, pix_ready drops once FIFO_DEPTH words queued, 8 writes total, no loss or duplication.
REQ-032 Zero size: rows=0, stride=5 -> no avl_write, pix_ready never 1, done=1 within 2 cycles.
REQ-033 Wrap: start_address=0x3FFFFFF, stride=2, rows=1 -> writes to 0x3FFFFFF then 0x0000000.
REQ-034 Reset mid-job: reset=0 after 6 pixels of stride=4, rows=1 -> done=1, avl_write=0 next cycle; new start writes from new start_address with fresh lane 0.
REQ-035 Busy start: second start pulsed while done=0 -> ignored; latched address/sizes unchanged.

Source files
------------

// File: rtl/ddr_write_back.sv
// ddr_write_back: packs 32-bit result pixels four to a 128-bit word, queues
// the words in a small FIFO and writes them to consecutive DDR3 word addresses
// over an Avalon-MM master port, one single-word burst per write.
module ddr_write_back #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         iCLK,
  input  logic         reset,
  input  logic         start,
  input  logic [25:0]  start_address,
  input  logic [9:0]   stride,
  input  logic [9:0]   rows,
  output logic         done,
  input  logic         pix_valid,
  input  logic [31:0]  pix_data,
  output logic         pix_ready,
  output logic [25:0]  avl_address,
  output logic [127:0] avl_writedata,
  output logic         avl_write,
  output logic         avl_read,
  output logic         avl_burstbegin,
  input  logic         avl_wait_request_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [25:0]  addr_q, addr_d;
  logic [19:0]  total_q, total_d;
  logic [21:0]  pix_cnt_q, pix_cnt_d;
  logic [19:0]  words_q, words_d;
  logic [1:0]   lane_q, lane_d;
  logic [95:0]  pack_q, pack_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]  count_q;
  logic [127:0] mem_q [FIFO_DEPTH];

  logic        run, empty, full, pop, push, pix_fire, accept, last_word;
  logic [19:0] start_total;

  assign run   = (state_q == S_RUN);
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees a slot on the same edge, so a full FIFO still takes a pixel
  // when the controller is accepting the head word.
  assign avl_write = run && !empty;
  assign pop       = avl_write && avl_wait_request_n;
  assign pix_ready = run && (!full || pop) && (pix_cnt_q < {total_q, 2'b00});
  assign pix_fire  = pix_valid && pix_ready;
  assign push      = pix_fire && (lane_q == 2'd3);

  assign done        = !run;
  assign accept      = start && done;
  assign start_total = {10'd0, stride} * {10'd0, rows};
  assign last_word   = pop && ((words_q + 20'd1) == total_q);

  // Memory contents are not reset, so gate the data bus to keep it zero
  // whenever no write is being presented.
  assign avl_address    = addr_q;
  assign avl_writedata  = avl_write ? mem_q[rd_ptr_q] : '0;
  assign avl_read       = 1'b0;
  assign avl_burstbegin = avl_write;

  // Next-state for job control, address/counters and the pixel packer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    total_d   = total_q;
    pix_cnt_d = pix_cnt_q;
    words_d   = words_q;
    lane_d    = lane_q;
    pack_d    = pack_q;
    case (state_q)
      S_RUN: begin
        if (pop) begin
          addr_d  = addr_q + 26'd1;
          words_d = words_q + 20'd1;
        end
        if (pix_fire) begin
          pix_cnt_d = pix_cnt_q + 22'd1;
          lane_d    = lane_q + 2'd1;
          case (lane_q)
            2'd0:    pack_d[31:0]  = pix_data;
            2'd1:    pack_d[63:32] = pix_data;
            2'd2:    pack_d[95:64] = pix_data;
            default: pack_d        = pack_q;
          endcase
        end
        if (last_word) state_d = S_DONE;
      end
      default: begin
        // Idle or finished: a start latches a new job; an empty job
        // never leaves the done condition.
        if (accept) begin
          state_d   = (start_total == 20'd0) ? S_DONE : S_RUN;
          addr_d    = start_address;
          total_d   = start_total;
          pix_cnt_d = '0;
          words_d   = '0;
          lane_d    = '0;
        end
      end
    endcase
  end

  // Control and counter registers; reset also aborts any job in progress.
  always_ff @(posedge iCLK) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      total_q   <= '0;
      pix_cnt_q <= '0;
      words_q   <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      total_q   <= total_d;
      pix_cnt_q <= pix_cnt_d;
      words_q   <= words_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge iCLK) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage: the fourth pixel goes straight into the word with lanes 0..2.
  always_ff @(posedge iCLK) begin
    if (push) mem_q[wr_ptr_q] <= {pix_data, pack_q};
  end

endmodule

// File: tb/tb_ddr_write_back.sv
// Directed bench for ddr_write_back: drives inputs 1ns after the rising edge,
// samples outputs on the falling edge, and logs accepted writes in a queue.
module tb_ddr_write_back;

  logic         iCLK = 1'b0;
  logic         reset;
  logic         start;
  logic [25:0]  start_address;
  logic [9:0]   stride;
  logic [9:0]   rows;
  logic         done;
  logic         pix_valid;
  logic [31:0]  pix_data;
  logic         pix_ready;
  logic [25:0]  avl_address;
  logic [127:0] avl_writedata;
  logic         avl_write;
  logic         avl_read;
  logic         avl_burstbegin;
  logic         avl_wait_request_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [25:0]  wq_addr[$];
  logic [127:0] wq_data[$];

  always #5 iCLK = ~iCLK;

  ddr_write_back #(.FIFO_DEPTH(2)) dut (
    .iCLK(iCLK), .reset(reset), .start(start), .start_address(start_address),
    .stride(stride), .rows(rows), .done(done), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .avl_address(avl_address),
    .avl_writedata(avl_writedata), .avl_write(avl_write), .avl_read(avl_read),
    .avl_burstbegin(avl_burstbegin), .avl_wait_request_n(avl_wait_request_n)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] word_of(input logic [31:0] base, input int j);
    logic [31:0] p0, p1, p2, p3;
    p0 = base + 32'(4*j);
    p1 = p0 + 32'd1;
    p2 = p0 + 32'd2;
    p3 = p0 + 32'd3;
    return {p3, p2, p1, p0};
  endfunction

  // Write logger plus hold check: a write stalled on one falling edge must be
  // presented unchanged on the next.
  initial begin
    logic         prev_stall;
    logic [25:0]  paddr;
    logic [127:0] pdata;
    prev_stall = 1'b0;
    paddr = '0;
    pdata = '0;
    forever begin
      @(negedge iCLK);
      if (reset === 1'b1) begin
        if (prev_stall) begin
          chk("hold_write", {127'd0, avl_write}, 128'd1);
          chk("hold_addr", {102'd0, avl_address}, {102'd0, paddr});
          chk("hold_data", avl_writedata, pdata);
        end
        if (avl_write && avl_wait_request_n) begin
          wq_addr.push_back(avl_address);
          wq_data.push_back(avl_writedata);
        end
        prev_stall = avl_write && !avl_wait_request_n;
        paddr = avl_address;
        pdata = avl_writedata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [25:0] a, input logic [9:0] s, input logic [9:0] r);
    start_address = a;
    stride = s;
    rows = r;
    start = 1'b1;
    @(posedge iCLK); #1;
    start = 1'b0;
  endtask

  // Feeds n pixels base, base+1, ... honouring pix_ready; returns cycles used.
  task automatic send(input logic [31:0] base, input int n, output int cycles);
    int i;
    logic acc;
    i = 0;
    cycles = 0;
    pix_valid = 1'b1;
    pix_data = base;
    while (i < n && cycles < 500) begin
      @(negedge iCLK);
      acc = pix_ready;
      @(posedge iCLK); #1;
      cycles++;
      if (acc) begin
        i++;
        pix_data = base + 32'(i);
      end
    end
    pix_valid = 1'b0;
    chk("send_timeout", 128'(i), 128'(n));
  endtask

  task automatic wait_done(input int bound);
    int c;
    c = 0;
    @(negedge iCLK);
    while (done !== 1'b1 && c < bound) begin
      @(negedge iCLK);
      c++;
    end
    chk("done_timeout", {127'd0, done}, 128'd1);
    @(posedge iCLK); #1;
  endtask

  task automatic chk_writes(input string tag, input logic [25:0] a0,
                            input logic [31:0] base, input int n);
    chk({tag, "_count"}, 128'(wq_addr.size()), 128'(n));
    for (int j = 0; j < n && j < wq_addr.size(); j++) begin
      chk({tag, "_addr"}, {102'd0, wq_addr[j]}, {102'd0, a0 + 26'(j)});
      chk({tag, "_data"}, wq_data[j], word_of(base, j));
    end
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b0;
    start = 1'b0;
    start_address = '0;
    stride = '0;
    rows = '0;
    pix_valid = 1'b0;
    pix_data = '0;
    avl_wait_request_n = 1'b1;

    // Reset state
    @(posedge iCLK); #1;
    @(negedge iCLK);
    chk("rst_done", {127'd0, done}, 128'd1);
    chk("rst_write", {127'd0, avl_write}, 128'd0);
    chk("rst_read", {127'd0, avl_read}, 128'd0);
    chk("rst_burst", {127'd0, avl_burstbegin}, 128'd0);
    chk("rst_addr", {102'd0, avl_address}, 128'd0);
    chk("rst_data", avl_writedata, 128'd0);
    chk("rst_ready", {127'd0, pix_ready}, 128'd0);
    @(posedge iCLK); #1;
    reset = 1'b1;
    @(posedge iCLK); #1;

    // Basic: two words, hand-computed values
    do_start(26'h100, 10'd2, 10'd1);
    @(negedge iCLK);
    chk("basic_busy", {127'd0, done}, 128'd0);
    @(posedge iCLK); #1;
    send(32'd1, 8, cyc);
    chk("basic_rate", 128'(cyc), 128'd8);
    wait_done(20);
    chk("basic_count", 128'(wq_addr.size()), 128'd2);
    if (wq_addr.size() == 2) begin
      chk("basic_a0", {102'd0, wq_addr[0]}, 128'h100);
      chk("basic_d0", wq_data[0], 128'h00000004_00000003_00000002_00000001);
      chk("basic_a1", {102'd0, wq_addr[1]}, 128'h101);
      chk("basic_d1", wq_data[1], 128'h00000008_00000007_00000006_00000005);
    end
    wq_addr.delete();
    wq_data.delete();

    // Stall: 8 words, controller busy for 10 cycles mid-job
    do_start(26'h200, 10'd4, 10'd2);
    fork
      send(32'h10, 32, cyc);
      begin
        repeat (6) @(posedge iCLK);
        #1 avl_wait_request_n = 1'b0;
        repeat (9) @(posedge iCLK);
        @(negedge iCLK);
        chk("stall_ready_low", {127'd0, pix_ready}, 128'd0);
        chk("stall_write_high", {127'd0, avl_write}, 128'd1);
        @(posedge iCLK);
        #1 avl_wait_request_n = 1'b1;
      end
    join
    wait_done(40);
    chk_writes("stall", 26'h200, 32'h10, 8);

    // Zero size: nothing accepted or written
    do_start(26'h50, 10'd5, 10'd0);
    pix_valid = 1'b1;
    repeat (3) begin
      @(negedge iCLK);
      chk("zero_ready", {127'd0, pix_ready}, 128'd0);
      chk("zero_write", {127'd0, avl_write}, 128'd0);
    end
    chk("zero_done", {127'd0, done}, 128'd1);
    @(posedge iCLK); #1;
    pix_valid = 1'b0;
    chk("zero_count", 128'(wq_addr.size()), 128'd0);

    // Address wrap
    do_start(26'h3FFFFFF, 10'd2, 10'd1);
    send(32'h100, 8, cyc);
    wait_done(20);
    chk("wrap_count", 128'(wq_addr.size()), 128'd2);
    if (wq_addr.size() == 2) begin
      chk("wrap_a0", {102'd0, wq_addr[0]}, 128'h3FFFFFF);
      chk("wrap_a1", {102'd0, wq_addr[1]}, 128'h0);
      chk("wrap_d1", wq_data[1], word_of(32'h100, 1));
    end
    wq_addr.delete();
    wq_data.delete();

    // Reset mid-job after 6 pixels, then a fresh job
    do_start(26'h300, 10'd4, 10'd1);
    send(32'hA0, 6, cyc);
    reset = 1'b0;
    @(posedge iCLK); #1;
    reset = 1'b1;
    @(negedge iCLK);
    chk("midrst_done", {127'd0, done}, 128'd1);
    chk("midrst_write", {127'd0, avl_write}, 128'd0);
    @(posedge iCLK); #1;
    wq_addr.delete();
    wq_data.delete();
    do_start(26'h400, 10'd1, 10'd1);
    send(32'hB0, 4, cyc);
    wait_done(20);
    chk_writes("after_rst", 26'h400, 32'hB0, 1);

    // Busy start ignored
    do_start(26'h500, 10'd1, 10'd2);
    do_start(26'h600, 10'd3, 10'd3);
    send(32'hC0, 8, cyc);
    wait_done(20);
    chk_writes("busy", 26'h500, 32'hC0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
